// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the D-stage controller and the W stage.
//   - WB_* : 3-bit writeback-source select encodings
//   - LD_* : 3-bit load width/sign encodings
//   - w_regs_t : contents of the M->W pipeline register
package cpu_defs;

  localparam int DATA_W = 32;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC8 = 3'd2;
  localparam logic [2:0] WB_MDU = 3'd3;
  localparam logic [2:0] WB_CP0 = 3'd4;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic              reg_wen;
    logic [4:0]        reg_addr;
    logic [2:0]        wb_sel;
    logic [2:0]        load_type;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mdu_res;
    logic [DATA_W-1:0] cp0_res;
  } w_regs_t;

endpackage

// File: rtl/load_ext.sv
// Load-data extraction and sign/zero extension (purely combinational).
// Ports:
//   raw_i       : aligned 32-bit DM word
//   addr_lo_i   : byte address [1:0]; halfword lane uses bit 1 only
//   load_type_i : LD_* encoding
//   data_o      : extended 32-bit load result
module load_ext
  import cpu_defs::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    // Misaligned halfwords are trapped upstream, so bit 0 is ignored.
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    data_o = raw_i;
    case (load_type_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {24'h000000, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data_o = {16'h0000, half_sel};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// M->W pipeline register and writeback-data selection.
// Ports:
//   clk, reset (async, active-low), stall (hold), flush (bubble; beats stall)
//   M_*  : M-stage results captured on each rising edge
//   W_valid, W_WPC, W_AddrW, W_DataW, W_WEn : GRF write port / W forwarding
// Outputs depend only on the W register, giving exactly one cycle latency.
module wb_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        M_valid,
  input  logic [31:0] M_PC,
  input  logic        M_RegWEn,
  input  logic [4:0]  M_RegAddr,
  input  logic [2:0]  M_WBSel,
  input  logic [2:0]  M_LoadType,
  input  logic [1:0]  M_AddrLo,
  input  logic [31:0] M_ALURes,
  input  logic [31:0] M_MemRData,
  input  logic [31:0] M_MDURes,
  input  logic [31:0] M_CP0Res,
  output logic        W_valid,
  output logic [31:0] W_WPC,
  output logic [4:0]  W_AddrW,
  output logic [31:0] W_DataW,
  output logic        W_WEn
);

  // Bubble and reset contents are identical: everything cleared, PC = RESET_PC.
  localparam w_regs_t BUBBLE = '{
    valid: 1'b0, pc: RESET_PC, reg_wen: 1'b0, reg_addr: 5'd0,
    wb_sel: WB_ALU, load_type: LD_W, addr_lo: 2'd0,
    alu_res: '0, mem_rdata: '0, mdu_res: '0, cp0_res: '0
  };

  w_regs_t w_q, w_d;
  logic [31:0] load_data;

  always_comb begin
    w_d = w_q;
    if (flush) begin
      w_d = BUBBLE;
    end else if (!stall) begin
      w_d.valid     = M_valid;
      w_d.pc        = M_PC;
      w_d.reg_wen   = M_RegWEn;
      w_d.reg_addr  = M_RegAddr;
      w_d.wb_sel    = M_WBSel;
      w_d.load_type = M_LoadType;
      w_d.addr_lo   = M_AddrLo;
      w_d.alu_res   = M_ALURes;
      w_d.mem_rdata = M_MemRData;
      w_d.mdu_res   = M_MDURes;
      w_d.cp0_res   = M_CP0Res;
    end
  end

  // ---- M -> W pipeline register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= BUBBLE;
    end else begin
      w_q <= w_d;
    end
  end

  load_ext u_load_ext (
    .raw_i       (w_q.mem_rdata),
    .addr_lo_i   (w_q.addr_lo),
    .load_type_i (w_q.load_type),
    .data_o      (load_data)
  );

  always_comb begin
    W_DataW = 32'h0;
    case (w_q.wb_sel)
      WB_ALU:  W_DataW = w_q.alu_res;
      WB_MEM:  W_DataW = load_data;
      WB_PC8:  W_DataW = w_q.pc + 32'd8;
      WB_MDU:  W_DataW = w_q.mdu_res;
      WB_CP0:  W_DataW = w_q.cp0_res;
      default: W_DataW = 32'h0;
    endcase
  end

  assign W_valid = w_q.valid;
  assign W_WPC   = w_q.pc;
  assign W_AddrW = w_q.reg_addr;
  // Writes to $0 are architecturally discarded, so never raise WEn for them.
  assign W_WEn   = w_q.valid & w_q.reg_wen & (w_q.reg_addr != 5'd0);

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import cpu_defs::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        M_valid, M_RegWEn;
  logic [31:0] M_PC, M_ALURes, M_MemRData, M_MDURes, M_CP0Res;
  logic [4:0]  M_RegAddr;
  logic [2:0]  M_WBSel, M_LoadType;
  logic [1:0]  M_AddrLo;
  logic        W_valid, W_WEn;
  logic [31:0] W_WPC, W_DataW;
  logic [4:0]  W_AddrW;

  int passed = 0;
  int total  = 0;

  wb_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .M_valid(M_valid), .M_PC(M_PC), .M_RegWEn(M_RegWEn), .M_RegAddr(M_RegAddr),
    .M_WBSel(M_WBSel), .M_LoadType(M_LoadType), .M_AddrLo(M_AddrLo),
    .M_ALURes(M_ALURes), .M_MemRData(M_MemRData), .M_MDURes(M_MDURes),
    .M_CP0Res(M_CP0Res),
    .W_valid(W_valid), .W_WPC(W_WPC), .W_AddrW(W_AddrW), .W_DataW(W_DataW),
    .W_WEn(W_WEn)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic wen,
                       input logic [4:0] addr, input logic [2:0] sel,
                       input logic [2:0] lt, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] mdu, input logic [31:0] cp0);
    M_valid = v; M_PC = pc; M_RegWEn = wen; M_RegAddr = addr; M_WBSel = sel;
    M_LoadType = lt; M_AddrLo = lo; M_ALURes = alu; M_MemRData = mem;
    M_MDURes = mdu; M_CP0Res = cp0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1, 32'h0000_0400, 1, 5'd7, WB_ALU, LD_W, 2'd0,
          32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    step(); step();
    total++; if (W_WEn !== 1'b0) $display("FAIL rst_wen got=%0b exp=0", W_WEn); else passed++;
    total++; if (W_AddrW !== 5'd0) $display("FAIL rst_addr got=%0d exp=0", W_AddrW); else passed++;
    total++; if (W_DataW !== 32'h0) $display("FAIL rst_data got=%h exp=0", W_DataW); else passed++;
    total++; if (W_WPC !== RST_PC) $display("FAIL rst_pc got=%h exp=%h", W_WPC, RST_PC); else passed++;
    total++; if (W_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", W_valid); else passed++;
    reset = 1'b1;
    #1;
    total++; if (W_WEn !== 1'b0) $display("FAIL rel_wen got=%0b exp=0", W_WEn); else passed++;
    step();
    total++; if (W_WEn !== 1'b1) $display("FAIL first_wen got=%0b exp=1", W_WEn); else passed++;
    total++; if (W_AddrW !== 5'd7) $display("FAIL first_addr got=%0d exp=7", W_AddrW); else passed++;
    total++; if (W_DataW !== 32'hDEAD_BEEF) $display("FAIL first_data got=%h exp=deadbeef", W_DataW); else passed++;
    total++; if (W_WPC !== 32'h0000_0400) $display("FAIL first_pc got=%h exp=00000400", W_WPC); else passed++;
  endtask

  task automatic test_loads();
    logic [2:0]  lt  [11] = '{LD_B, LD_B, LD_B, LD_B, LD_BU, LD_H, LD_HU,
                              LD_W, 3'd5, LD_BU, LD_H};
    logic [1:0]  lo  [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0,
                              2'd2, 2'd1, 2'd0, 2'd1};
    logic [31:0] exp [11] = '{32'hFFFF_FFA1, 32'hFFFF_FFC0, 32'h0000_007F,
                              32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_807F,
                              32'h0000_C0A1, 32'h807F_C0A1, 32'h807F_C0A1,
                              32'h0000_00A1, 32'hFFFF_C0A1};
    for (int i = 0; i < 11; i++) begin
      drive(1, 32'h0000_1000, 1, 5'd3, WB_MEM, lt[i], lo[i],
            32'h5555_5555, 32'h807F_C0A1, 32'h6666_6666, 32'h7777_7777);
      step();
      total++;
      if (W_DataW !== exp[i])
        $display("FAIL load[%0d] lt=%0d lo=%0d got=%h exp=%h", i, lt[i], lo[i], W_DataW, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_wbsel();
    logic [2:0]  sel [5] = '{WB_ALU, WB_MDU, WB_CP0, 3'd5, 3'd7};
    logic [31:0] exp [5] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003,
                             32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h0000_2000, 1, 5'd4, sel[i], LD_W, 2'd0,
            32'hA1A1_0001, 32'hFFFF_FFFF, 32'hB2B2_0002, 32'hC3C3_0003);
      step();
      total++;
      if (W_DataW !== exp[i])
        $display("FAIL wbsel[%0d] sel=%0d got=%h exp=%h", i, sel[i], W_DataW, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_jal();
    drive(1, 32'h0000_3000, 1, 5'd31, WB_PC8, LD_W, 2'd0,
          32'h0, 32'h0, 32'h0, 32'h0);
    step();
    total++; if (W_DataW !== 32'h0000_3008) $display("FAIL jal_data got=%h exp=00003008", W_DataW); else passed++;
    total++; if (W_AddrW !== 5'd31) $display("FAIL jal_addr got=%0d exp=31", W_AddrW); else passed++;
    total++; if (W_WEn !== 1'b1) $display("FAIL jal_wen got=%0b exp=1", W_WEn); else passed++;
    total++; if (W_WPC !== 32'h0000_3000) $display("FAIL jal_pc got=%h exp=00003000", W_WPC); else passed++;
    // New M values must not reach W before the next edge.
    drive(1, 32'h0000_9000, 1, 5'd2, WB_ALU, LD_W, 2'd0,
          32'h4444_4444, 32'h0, 32'h0, 32'h0);
    #2;
    total++; if (W_DataW !== 32'h0000_3008) $display("FAIL no_comb_path got=%h exp=00003008", W_DataW); else passed++;
  endtask

  task automatic test_zero_and_bubble();
    drive(1, 32'h0000_4000, 1, 5'd0, WB_ALU, LD_W, 2'd0,
          32'h1, 32'h0, 32'h0, 32'h0);
    step();
    total++; if (W_WEn !== 1'b0) $display("FAIL r0_wen got=%0b exp=0", W_WEn); else passed++;
    drive(0, 32'h0000_4004, 1, 5'd5, WB_ALU, LD_W, 2'd0,
          32'h2, 32'h0, 32'h0, 32'h0);
    step();
    total++; if (W_WEn !== 1'b0) $display("FAIL bubble_wen got=%0b exp=0", W_WEn); else passed++;
    total++; if (W_DataW !== 32'h2) $display("FAIL bubble_data got=%h exp=00000002", W_DataW); else passed++;
  endtask

  task automatic test_stall_flush();
    drive(1, 32'h0000_0100, 1, 5'd8, WB_ALU, LD_W, 2'd0,
          32'h1234_5678, 32'h0, 32'h0, 32'h0);
    step();
    total++; if (W_DataW !== 32'h1234_5678) $display("FAIL cap_data got=%h exp=12345678", W_DataW); else passed++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 32'h0000_0200 + 32'(i), 1, 5'd9 + 5'(i), WB_MDU, LD_B, 2'd1,
            32'hFFFF_0000, 32'h0, 32'hAAAA_0000 + 32'(i), 32'h0);
      step();
      total++;
      if (W_DataW !== 32'h1234_5678 || W_AddrW !== 5'd8 || W_WEn !== 1'b1 ||
          W_WPC !== 32'h0000_0100)
        $display("FAIL stall_hold[%0d] got data=%h addr=%0d wen=%0b pc=%h exp data=12345678 addr=8 wen=1 pc=00000100",
                 i, W_DataW, W_AddrW, W_WEn, W_WPC);
      else passed++;
    end
    flush = 1'b1;
    step();
    total++; if (W_valid !== 1'b0) $display("FAIL flush_valid got=%0b exp=0", W_valid); else passed++;
    total++; if (W_WEn !== 1'b0) $display("FAIL flush_wen got=%0b exp=0", W_WEn); else passed++;
    total++; if (W_WPC !== RST_PC) $display("FAIL flush_pc got=%h exp=%h", W_WPC, RST_PC); else passed++;
    total++; if (W_DataW !== 32'h0) $display("FAIL flush_data got=%h exp=0", W_DataW); else passed++;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1, 32'h0000_5000, 1, 5'd12, WB_ALU, LD_W, 2'd0,
          32'hCAFE_F00D, 32'h0, 32'h0, 32'h0);
    step();
    stall = 1'b1;
    step();
    total++; if (W_WEn !== 1'b1) $display("FAIL pre_areset_wen got=%0b exp=1", W_WEn); else passed++;
    #1;   // between edges: 2 ns after posedge
    reset = 1'b0;
    #1;
    total++; if (W_WEn !== 1'b0) $display("FAIL areset_wen got=%0b exp=0", W_WEn); else passed++;
    total++; if (W_WPC !== RST_PC) $display("FAIL areset_pc got=%h exp=%h", W_WPC, RST_PC); else passed++;
    total++; if (W_DataW !== 32'h0) $display("FAIL areset_data got=%h exp=0", W_DataW); else passed++;
    step();
    reset = 1'b1; stall = 1'b0;
    step();
    total++; if (W_DataW !== 32'hCAFE_F00D) $display("FAIL post_areset_data got=%h exp=cafef00d", W_DataW); else passed++;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_wbsel();
    test_jal();
    test_zero_and_bubble();
    test_stall_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
